// File: rtl/sync_fifo_if.sv
// Handshake bundle between a same-clock producer/consumer and sync_fifo.
// master: the side that pushes/pops (drives winc/wdata/rinc).
// slave : the FIFO itself (drives data, flags, count and error pulses).
//   winc, wdata            write request and its data
//   wfull, walmost_full    write-side flags
//   rinc                   read request (pop)
//   rdata, rvalid          registered read data and its qualifier
//   rempty, ralmost_empty  read-side flags
//   count                  occupancy, 0..2**ADDR_WIDTH
//   overflow, underflow    one-cycle pulses for dropped writes / ignored reads
interface sync_fifo_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  winc;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wfull;
  logic                  walmost_full;
  logic                  rinc;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  rempty;
  logic                  ralmost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output winc, wdata, rinc,
    input  wfull, walmost_full, rdata, rvalid, rempty, ralmost_empty, count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc,
    output wfull, walmost_full, rdata, rvalid, rempty, ralmost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock parametrised FIFO with registered flags, occupancy count, almost thresholds,
// a registered read port and overflow/underflow pulses.
// Ports:
//   clk  single clock, all state on posedge
//   rst  synchronous active-high reset, overrides winc/rinc
//   bus  sync_fifo_if.slave: winc/wdata/rinc in; rdata/rvalid, flags, count, pulses out
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through. The head word is
// prefetched into the output register, so rdata always shows the head and rvalid = ~rempty.
// Without it, an accepted read returns its word on rdata one cycle later with rvalid=1.
module sync_fifo #(
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned AFULL_THRESH  = 2**ADDR_WIDTH - 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic        clk,
  input  logic        rst,
  sync_fifo_if.slave  bus
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
  localparam int unsigned PW    = ADDR_WIDTH + 1;

  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t DepthP  = ptr_t'(DEPTH);
  localparam ptr_t AfullP  = ptr_t'(AFULL_THRESH);
  localparam ptr_t AemptyP = ptr_t'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  ptr_t                  wptr_q, wptr_d;
  ptr_t                  rptr_q, rptr_d;
  ptr_t                  count_q, count_d;
  logic                  wfull_q, wfull_d;
  logic                  walmost_full_q, walmost_full_d;
  logic                  rempty_q, rempty_d;
  logic                  ralmost_empty_q, ralmost_empty_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  overflow_q, underflow_q;

  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] mem_rd;

  assign wr_acc = bus.winc & ~wfull_q;
  assign rd_acc = bus.rinc & ~rempty_q;
  assign mem_rd = mem_q[rptr_q[ADDR_WIDTH-1:0]];

  // Occupancy counts accepted transfers at the FIFO boundary in both modes.
  always_comb begin
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ptr_t'(1);
      2'b01:   count_d = count_q - ptr_t'(1);
      default: count_d = count_q;
    endcase
    walmost_full_d  = (count_d >= AfullP);
    ralmost_empty_d = (count_d <= AemptyP);
  end

  assign wptr_d = wptr_q + ptr_t'(wr_acc);

`ifdef SYNC_FIFO_FWFT_EN
  logic mem_empty_q, mem_empty_d;
  logic load;

  // Refill the output register whenever it is free or being popped this edge. mem_empty_q
  // is registered, so a word written into an empty array is seen one edge later.
  always_comb begin
    load        = ~mem_empty_q & (~rvalid_q | rd_acc);
    rptr_d      = rptr_q + ptr_t'(load);
    rvalid_d    = load | (rvalid_q & ~rd_acc);
    rdata_d     = load ? mem_rd : rdata_q;
    rempty_d    = ~rvalid_d;
    mem_empty_d = (wptr_d == rptr_d);
    // The array plus output register can hold DEPTH+1 words; cap at DEPTH via count.
    wfull_d     = (count_d == DepthP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_empty_q <= 1'b1;
    end else begin
      mem_empty_q <= mem_empty_d;
    end
  end
`else
  always_comb begin
    rptr_d   = rptr_q + ptr_t'(rd_acc);
    rvalid_d = rd_acc;
    rdata_d  = rd_acc ? mem_rd : rdata_q;
    rempty_d = (wptr_d == rptr_d);
    // Same array address with opposite wrap bits means the writer is a full lap ahead.
    wfull_d  = (wptr_d[ADDR_WIDTH-1:0] == rptr_d[ADDR_WIDTH-1:0]) &&
               (wptr_d[ADDR_WIDTH] != rptr_d[ADDR_WIDTH]);
  end
`endif

  // Storage is not reset; stale words are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem_q[wptr_q[ADDR_WIDTH-1:0]] <= bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q          <= '0;
      rptr_q          <= '0;
      count_q         <= '0;
      wfull_q         <= 1'b0;
      walmost_full_q  <= 1'b0;
      rempty_q        <= 1'b1;
      ralmost_empty_q <= 1'b1;
      rvalid_q        <= 1'b0;
      rdata_q         <= '0;
      overflow_q      <= 1'b0;
      underflow_q     <= 1'b0;
    end else begin
      wptr_q          <= wptr_d;
      rptr_q          <= rptr_d;
      count_q         <= count_d;
      wfull_q         <= wfull_d;
      walmost_full_q  <= walmost_full_d;
      rempty_q        <= rempty_d;
      ralmost_empty_q <= ralmost_empty_d;
      rvalid_q        <= rvalid_d;
      rdata_q         <= rdata_d;
      overflow_q      <= bus.winc & wfull_q;
      underflow_q     <= bus.rinc & rempty_q;
    end
  end

  assign bus.wfull         = wfull_q;
  assign bus.walmost_full  = walmost_full_q;
  assign bus.rempty        = rempty_q;
  assign bus.ralmost_empty = ralmost_empty_q;
  assign bus.rvalid        = rvalid_q;
  assign bus.rdata         = rdata_q;
  assign bus.count         = count_q;
  assign bus.overflow      = overflow_q;
  assign bus.underflow     = underflow_q;

endmodule
